// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating counters: predicts the next PC for IF and trains from ID.
// Latency: lookup and resolve are combinational (0 cycles); training and statistics land on the next clk edge.
// Backpressure: none; one lookup and one update are accepted every cycle, with no stall path.
module branch_predictor_btb #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int TAG_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_is_jump,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_pred_taken,
    input  logic [ADDR_WIDTH-1:0] update_pred_target,
    input  logic                  flush_all,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0]   CTR_MAX     = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]   CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0]   CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4);

    // Table state; tag/target/counter live in arrays indexed by pc[IDX_W+1:2]
    logic [ENTRIES-1:0]    validQ;
    logic [ENTRIES-1:0]    isJumpQ;
    logic [TAG_BITS-1:0]   tagQ    [ENTRIES];
    logic [ADDR_WIDTH-1:0] targetQ [ENTRIES];
    logic [CTR_BITS-1:0]   ctrQ    [ENTRIES];

    logic [STAT_WIDTH-1:0] statBranchesQ;
    logic [STAT_WIDTH-1:0] statMispredQ;

    logic [IDX_W-1:0]    lookIdx;
    logic [TAG_BITS-1:0] lookTag;
    logic [IDX_W-1:0]    updIdx;
    logic [TAG_BITS-1:0] updTag;
    logic                updHit;
    logic                effTaken;

    assign lookIdx = lookup_pc[IDX_W+1:2];
    assign lookTag = lookup_pc[IDX_W+1+TAG_BITS:IDX_W+2];
    assign updIdx  = update_pc[IDX_W+1:2];
    assign updTag  = update_pc[IDX_W+1+TAG_BITS:IDX_W+2];
    assign updHit  = validQ[updIdx] && (tagQ[updIdx] == updTag);

    // Jumps are always taken regardless of the reported branch outcome
    assign effTaken = update_taken | update_is_jump;

    // IF-side lookup reads only registered state, so a same-cycle update is not visible yet
    always_comb begin
        pred_hit    = validQ[lookIdx] && (tagQ[lookIdx] == lookTag);
        pred_taken  = pred_hit && (isJumpQ[lookIdx] || ctrQ[lookIdx][CTR_BITS-1]);
        pred_target = pred_taken ? targetQ[lookIdx] : lookup_pc + PC_STEP;
    end

    // ID-side resolve: compare the carried prediction against the actual outcome
    always_comb begin
        mispredict  = update_valid &&
                      ((effTaken != update_pred_taken) ||
                       (effTaken && (update_pred_target != update_target)));
        redirect_pc = effTaken ? update_target : update_pc + PC_STEP;
    end

    // Table training; flush beats a concurrent update, reset beats everything
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ  <= '0;
            isJumpQ <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= CTR_WEAK_NT;
            end
        end else if (flush_all) begin
            validQ <= '0;
        end else if (update_valid) begin
            if (updHit) begin
                if (effTaken) begin
                    if (ctrQ[updIdx] != CTR_MAX) begin
                        ctrQ[updIdx] <= ctrQ[updIdx] + CTR_BITS'(1);
                    end
                    targetQ[updIdx] <= update_target;
                end else if (ctrQ[updIdx] != '0) begin
                    ctrQ[updIdx] <= ctrQ[updIdx] - CTR_BITS'(1);
                end
                isJumpQ[updIdx] <= update_is_jump;
            end else if (effTaken) begin
                validQ[updIdx]  <= 1'b1;
                isJumpQ[updIdx] <= update_is_jump;
                tagQ[updIdx]    <= updTag;
                targetQ[updIdx] <= update_target;
                ctrQ[updIdx]    <= update_is_jump ? CTR_MAX : CTR_WEAK_T;
            end
        end
    end

    // Saturating statistics counters; a flush does not clear them
    always_ff @(posedge clk) begin
        if (reset) begin
            statBranchesQ <= '0;
            statMispredQ  <= '0;
        end else begin
            if (update_valid && (statBranchesQ != '1)) begin
                statBranchesQ <= statBranchesQ + STAT_WIDTH'(1);
            end
            if (mispredict && (statMispredQ != '1)) begin
                statMispredQ <= statMispredQ + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_branches    = statBranchesQ;
    assign stat_mispredicts = statMispredQ;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Testbench for branch_predictor_btb: default build plus a STAT_WIDTH=4 build for saturation.
// Stimulus queues expected responses; a negedge monitor pops and compares them.
// Both instances share inputs; the narrow build is held in reset until its own phase.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        resetA = 1'b1;
    logic        resetB = 1'b1;
    logic [31:0] lookupPc = '0;
    logic        updValid = 1'b0;
    logic [31:0] updPc = '0;
    logic        updIsJump = 1'b0;
    logic        updTaken = 1'b0;
    logic [31:0] updTarget = '0;
    logic        updPredTaken = 1'b0;
    logic [31:0] updPredTarget = '0;
    logic        flushAll = 1'b0;

    logic        aHit, aTaken, aMis;
    logic [31:0] aTgt, aRedir;
    logic [15:0] aStatB, aStatM;
    logic        bHit, bTaken, bMis;
    logic [31:0] bTgt, bRedir;
    logic [3:0]  bStatB, bStatM;

    always #5 clk = ~clk;

    branch_predictor_btb dutA (
        .clk(clk), .reset(resetA), .lookup_pc(lookupPc),
        .pred_hit(aHit), .pred_taken(aTaken), .pred_target(aTgt),
        .update_valid(updValid), .update_pc(updPc), .update_is_jump(updIsJump),
        .update_taken(updTaken), .update_target(updTarget),
        .update_pred_taken(updPredTaken), .update_pred_target(updPredTarget),
        .flush_all(flushAll), .mispredict(aMis), .redirect_pc(aRedir),
        .stat_branches(aStatB), .stat_mispredicts(aStatM)
    );

    branch_predictor_btb #(.STAT_WIDTH(4)) dutB (
        .clk(clk), .reset(resetB), .lookup_pc(lookupPc),
        .pred_hit(bHit), .pred_taken(bTaken), .pred_target(bTgt),
        .update_valid(updValid), .update_pc(updPc), .update_is_jump(updIsJump),
        .update_taken(updTaken), .update_target(updTarget),
        .update_pred_taken(updPredTaken), .update_pred_target(updPredTarget),
        .flush_all(flushAll), .mispredict(bMis), .redirect_pc(bRedir),
        .stat_branches(bStatB), .stat_mispredicts(bStatM)
    );

    typedef struct {
        int          dutSel;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic        mis;
        logic        chkRedir;
        logic [31:0] redir;
        logic [31:0] statB;
        logic [31:0] statM;
    } exp_t;

    exp_t expQ[$];
    logic chkVld = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   curDut = 0;

    task automatic chk(input string name, input int dutSel, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h, expected 0x%0h", name, dutSel, $time, act, req);
        end
    endtask

    // Monitor: on each falling edge with a strobe, compare every queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chkVld) begin
                while (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    if (e.dutSel == 0) begin
                        chk("pred_hit", 0, {31'b0, aHit}, {31'b0, e.hit});
                        chk("pred_taken", 0, {31'b0, aTaken}, {31'b0, e.taken});
                        chk("pred_target", 0, aTgt, e.tgt);
                        chk("mispredict", 0, {31'b0, aMis}, {31'b0, e.mis});
                        if (e.chkRedir) chk("redirect_pc", 0, aRedir, e.redir);
                        chk("stat_branches", 0, {16'b0, aStatB}, e.statB);
                        chk("stat_mispredicts", 0, {16'b0, aStatM}, e.statM);
                    end else begin
                        chk("pred_hit", 1, {31'b0, bHit}, {31'b0, e.hit});
                        chk("pred_taken", 1, {31'b0, bTaken}, {31'b0, e.taken});
                        chk("pred_target", 1, bTgt, e.tgt);
                        chk("mispredict", 1, {31'b0, bMis}, {31'b0, e.mis});
                        if (e.chkRedir) chk("redirect_pc", 1, bRedir, e.redir);
                        chk("stat_branches", 1, {28'b0, bStatB}, e.statB);
                        chk("stat_mispredicts", 1, {28'b0, bStatM}, e.statM);
                    end
                end
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, queue the expected response, advance
    task automatic cyc(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic uj, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt, input logic fl,
                       input logic eHit, input logic eTaken, input logic [31:0] eTgt,
                       input logic eMis, input logic [31:0] eRedir, input int eB, input int eM);
        exp_t e;
        lookupPc = lpc; updValid = uv; updPc = upc; updIsJump = uj; updTaken = ut;
        updTarget = utgt; updPredTaken = upt; updPredTarget = uptgt; flushAll = fl;
        e.dutSel = curDut; e.hit = eHit; e.taken = eTaken; e.tgt = eTgt;
        e.mis = eMis; e.chkRedir = uv; e.redir = eRedir;
        e.statB = eB; e.statM = eM;
        expQ.push_back(e);
        chkVld = 1'b1;
        @(posedge clk);
        #1;
        chkVld = 1'b0;
    endtask

    task automatic look(input logic [31:0] lpc, input logic eHit, input logic eTaken,
                        input logic [31:0] eTgt, input int eB, input int eM);
        cyc(lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,
            eHit, eTaken, eTgt, 1'b0, 32'h0, eB, eM);
    endtask

    localparam logic [31:0] BEQ  = 32'h0040_0020;
    localparam logic [31:0] BEQN = 32'h0040_0024;
    localparam logic [31:0] BT   = 32'h0040_0040;
    localparam logic [31:0] ALI  = 32'h0040_0060;
    localparam logic [31:0] JR   = 32'h0040_0030;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetA = 1'b0;
        curDut = 0;
        // Reset state
        look(32'h0040_0010, 0, 0, 32'h0040_0014, 0, 0);
        // First taken beq allocates; same-cycle lookup still misses
        cyc(BEQ, 1, BEQ, 0, 1, BT, 0, BEQN, 0,  0, 0, BEQN,  1, BT, 0, 0);
        look(BEQ, 1, 1, BT, 1, 1);
        // Three not-taken then one taken: counter 2->1->0->0->1
        cyc(BEQ, 1, BEQ, 0, 0, BT, 1, BT,   0,  1, 1, BT,    1, BEQN, 1, 1);
        cyc(BEQ, 1, BEQ, 0, 0, BT, 0, BEQN, 0,  1, 0, BEQN,  0, BEQN, 2, 2);
        cyc(BEQ, 1, BEQ, 0, 0, BT, 0, BEQN, 0,  1, 0, BEQN,  0, BEQN, 3, 2);
        cyc(BEQ, 1, BEQ, 0, 1, BT, 0, BEQN, 0,  1, 0, BEQN,  1, BT, 4, 2);
        look(BEQ, 1, 0, BEQN, 5, 3);
        // Climb to the top and saturate, then one not-taken stays predicted taken
        cyc(BEQ, 1, BEQ, 0, 1, BT, 0, BEQN, 0,  1, 0, BEQN,  1, BT, 5, 3);
        cyc(BEQ, 1, BEQ, 0, 1, BT, 1, BT,   0,  1, 1, BT,    0, BT, 6, 4);
        cyc(BEQ, 1, BEQ, 0, 1, BT, 1, BT,   0,  1, 1, BT,    0, BT, 7, 4);
        cyc(BEQ, 1, BEQ, 0, 0, BT, 1, BT,   0,  1, 1, BT,    1, BEQN, 8, 4);
        look(BEQ, 1, 1, BT, 9, 5);
        // Aliasing: same index, different tag replaces the entry
        cyc(ALI, 1, ALI, 0, 1, 32'h0040_0080, 0, 32'h0040_0064, 0,
            0, 0, 32'h0040_0064, 1, 32'h0040_0080, 9, 5);
        look(BEQ, 0, 0, BEQN, 10, 6);
        look(ALI, 1, 1, 32'h0040_0080, 10, 6);
        // jr allocates as jump, then a new target mispredicts and retrains
        cyc(JR, 1, JR, 1, 0, 32'h0040_0100, 0, 32'h0040_0034, 0,
            0, 0, 32'h0040_0034, 1, 32'h0040_0100, 10, 6);
        cyc(JR, 1, JR, 1, 0, 32'h0040_0200, 1, 32'h0040_0100, 0,
            1, 1, 32'h0040_0100, 1, 32'h0040_0200, 11, 7);
        look(JR, 1, 1, 32'h0040_0200, 12, 8);
        // Flush together with an update: table invalid, branch still counted
        cyc(JR, 1, JR, 1, 0, 32'h0040_0200, 1, 32'h0040_0200, 1,
            1, 1, 32'h0040_0200, 0, 32'h0040_0200, 12, 8);
        look(JR, 0, 0, 32'h0040_0034, 13, 8);
        look(ALI, 0, 0, 32'h0040_0064, 13, 8);
        // Address wrap on both fall-through paths; not-taken miss does not allocate
        cyc(32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0, 0,
            0, 0, 32'h0, 0, 32'h0, 13, 8);
        look(32'hFFFF_FFFC, 0, 0, 32'h0, 14, 8);

        // Narrow-stats build: 2^4+3 mispredicting updates saturate both counters at 0xF
        resetB = 1'b0;
        curDut = 1;
        for (int i = 0; i < 19; i++) begin
            cyc(BEQ, 1, BEQ, 0, 1, BT, 0, BEQN, 0,
                (i > 0), (i > 0), (i > 0) ? BT : BEQN, 1, BT,
                (i < 15) ? i : 15, (i < 15) ? i : 15);
        end
        look(BEQ, 1, 1, BT, 15, 15);
        // Reset in the middle of the burst: pre-edge outputs unchanged, then cleared
        resetB = 1'b1;
        cyc(BEQ, 1, BEQ, 0, 1, BT, 0, BEQN, 0,  1, 1, BT,   1, BT, 15, 15);
        resetB = 1'b0;
        cyc(BEQ, 1, BEQ, 0, 1, BT, 0, BEQN, 0,  0, 0, BEQN, 1, BT, 0, 0);
        look(BEQ, 1, 1, BT, 1, 1);

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
